// File: rtl/sbox_share_sched.sv
// Shares LANES AES S-boxes between the round datapath (ST, 128-bit SubBytes) and key
// expansion (KY, 32-bit SubWord) with round-robin arbitration and an in-place result buffer.
module sbox_share_sched #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_in_valid,
    output logic         st_in_ready,
    input  logic [127:0] st_in_data,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         ky_in_valid,
    output logic         ky_in_ready,
    input  logic [31:0]  ky_in_data,
    output logic         ky_out_valid,
    input  logic         ky_out_ready,
    output logic [31:0]  ky_out_data,
    output logic         busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sbox_share_sched: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam int unsigned ST_PASSES = 16 / LANES;
    localparam int unsigned KY_PASSES = (LANES >= 4) ? 1 : 4 / LANES;
    localparam int unsigned CNT_W     = (ST_PASSES > 1) ? $clog2(ST_PASSES) : 1;
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(ST_PASSES - 1);
    localparam logic [CNT_W-1:0] KY_LAST = CNT_W'(KY_PASSES - 1);

    // AES forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lut(input logic [7:0] x);
        return SBOX_TABLE[{8'hff - x, 3'b000} +: 8];
    endfunction

    typedef enum logic [2:0] {
        StIdle,
        StStRun,
        StKyRun,
        StStDone,
        StKyDone
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [127:0]       buf_q;
    logic               last_ky_q;
    logic               st_out_valid_q;
    logic               ky_out_valid_q;

    logic               idle;
    logic               ky_grant;
    logic               st_grant;
    logic [3:0]         base;
    logic [7:0]         lane_in  [LANES];
    logic [7:0]         lane_out [LANES];
    logic [LANES-1:0]   lane_en;
    logic [127:0]       run_buf;

    // Round robin: KY wins a tie unless it was the last one served.
    assign idle     = (state_q == StIdle);
    assign ky_grant = idle && ky_in_valid && (!st_in_valid || !last_ky_q);
    assign st_grant = idle && st_in_valid && !ky_grant;

    assign ky_in_ready = rst_n && ky_grant;
    assign st_in_ready = rst_n && st_grant;

    assign base = 4'(LANES * int'(cnt_q));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l]  = buf_q[{base + 4'(l), 3'b000} +: 8];
        assign lane_out[l] = sbox_lut(lane_in[l]);
        // A KY word only spans bytes 0..3, so wider banks leave the upper lanes idle.
        if (l < 4) begin : g_word_lane
            assign lane_en[l] = 1'b1;
        end else begin : g_state_lane
            assign lane_en[l] = (state_q == StStRun);
        end
    end

    always_comb begin
        run_buf = buf_q;
        for (int l = 0; l < LANES; l++) begin
            if (lane_en[l]) begin
                run_buf[{base + 4'(l), 3'b000} +: 8] = lane_out[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            buf_q          <= '0;
            last_ky_q      <= 1'b0;
            st_out_valid_q <= 1'b0;
            ky_out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ky_grant) begin
                        buf_q     <= {96'b0, ky_in_data};
                        cnt_q     <= '0;
                        last_ky_q <= 1'b1;
                        state_q   <= StKyRun;
                    end else if (st_grant) begin
                        buf_q     <= st_in_data;
                        cnt_q     <= '0;
                        last_ky_q <= 1'b0;
                        state_q   <= StStRun;
                    end
                end
                StStRun: begin
                    buf_q <= run_buf;
                    if (cnt_q == ST_LAST) begin
                        state_q        <= StStDone;
                        st_out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StKyRun: begin
                    buf_q <= run_buf;
                    if (cnt_q == KY_LAST) begin
                        state_q        <= StKyDone;
                        ky_out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StStDone: begin
                    if (st_out_ready) begin
                        state_q        <= StIdle;
                        st_out_valid_q <= 1'b0;
                    end
                end
                StKyDone: begin
                    if (ky_out_ready) begin
                        state_q        <= StIdle;
                        ky_out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= StIdle;
                    st_out_valid_q <= 1'b0;
                    ky_out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign st_out_valid = st_out_valid_q;
    assign ky_out_valid = ky_out_valid_q;
    assign st_out_data  = st_out_valid_q ? buf_q : '0;
    assign ky_out_data  = ky_out_valid_q ? buf_q[31:0] : '0;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_sbox_share_sched.sv
// Directed bench for sbox_share_sched: default LANES=4 instance plus LANES=1/2/8/16 instances
// checked against hand-computed AES S-box results.
module tb_sbox_share_sched;

    localparam logic [127:0] ST_VEC   = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
    localparam logic [127:0] ST_RES   = 128'h3052411ee55db4b8f198bfe0ae1127d4;
    localparam logic [127:0] ST0_RES  = 128'h63636363636363636363636363636363;
    localparam logic [31:0]  KY_VEC   = 32'h093c4fcf;
    localparam logic [31:0]  KY_RES   = 32'h01eb848a;
    localparam logic [31:0]  KY_VEC2  = 32'h00000053;
    localparam logic [31:0]  KY_RES2  = 32'h636363ed;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         st_in_valid, st_in_ready, st_out_valid, st_out_ready;
    logic [127:0] st_in_data, st_out_data;
    logic         ky_in_valid, ky_in_ready, ky_out_valid, ky_out_ready;
    logic [31:0]  ky_in_data, ky_out_data;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sbox_share_sched u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_in_valid  (st_in_valid),
        .st_in_ready  (st_in_ready),
        .st_in_data   (st_in_data),
        .st_out_valid (st_out_valid),
        .st_out_ready (st_out_ready),
        .st_out_data  (st_out_data),
        .ky_in_valid  (ky_in_valid),
        .ky_in_ready  (ky_in_ready),
        .ky_in_data   (ky_in_data),
        .ky_out_valid (ky_out_valid),
        .ky_out_ready (ky_out_ready),
        .ky_out_data  (ky_out_data),
        .busy         (busy)
    );

    // Instances 0..3 use LANES = 1, 2, 8, 16.
    logic         aux_st_valid, aux_ky_valid;
    logic         aux_st_ready [4];
    logic         aux_ky_ready [4];
    logic         aux_st_ovld  [4];
    logic         aux_ky_ovld  [4];
    logic [127:0] aux_st_data  [4];
    logic [31:0]  aux_ky_data  [4];
    logic         aux_busy     [4];
    int           exp_st_lat   [4] = '{16, 8, 2, 1};
    int           exp_ky_lat   [4] = '{4, 2, 1, 1};

    for (genvar g = 0; g < 4; g++) begin : g_aux
        localparam int unsigned L = (g < 2) ? (1 << g) : (1 << (g + 1));
        sbox_share_sched #(.LANES(L)) u_aux (
            .clk          (clk),
            .rst_n        (rst_n),
            .st_in_valid  (aux_st_valid),
            .st_in_ready  (aux_st_ready[g]),
            .st_in_data   (ST_VEC),
            .st_out_valid (aux_st_ovld[g]),
            .st_out_ready (1'b1),
            .st_out_data  (aux_st_data[g]),
            .ky_in_valid  (aux_ky_valid),
            .ky_in_ready  (aux_ky_ready[g]),
            .ky_in_data   (KY_VEC),
            .ky_out_valid (aux_ky_ovld[g]),
            .ky_out_ready (1'b1),
            .ky_out_data  (aux_ky_data[g]),
            .busy         (aux_busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after the acceptance edge; lat counts edges until out_valid is seen.
    task automatic wait_out(input bit ky, output int lat, output logic [127:0] dout);
        lat  = -1;
        dout = '0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (ky ? ky_out_valid : st_out_valid) begin
                lat  = c;
                dout = ky ? {96'b0, ky_out_data} : st_out_data;
                break;
            end
        end
    endtask

    task automatic run_job(input bit ky, input logic [127:0] din, output int lat,
                           output logic [127:0] dout);
        if (ky) begin
            ky_in_valid = 1'b1;
            ky_in_data  = din[31:0];
        end else begin
            st_in_valid = 1'b1;
            st_in_data  = din;
        end
        #1;
        check(ky ? "job_ky_ready" : "job_st_ready", 128'(ky ? ky_in_ready : st_in_ready), 128'(1));
        @(posedge clk); #1;
        ky_in_valid = 1'b0;
        st_in_valid = 1'b0;
        wait_out(ky, lat, dout);
        @(posedge clk); #1;
        check("job_valid_drop", 128'(ky ? ky_out_valid : st_out_valid), 128'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           busy_n;
        bit           exp_ky;
        logic [127:0] res;
        int           aux_lat [4];
        logic [127:0] aux_res [4];

        rst_n        = 1'b0;
        st_out_ready = 1'b1;
        ky_out_ready = 1'b1;
        st_in_valid  = 1'b1;
        ky_in_valid  = 1'b1;
        st_in_data   = ST_VEC;
        ky_in_data   = KY_VEC;
        aux_st_valid = 1'b0;
        aux_ky_valid = 1'b0;

        // Reset state, with both requests pending.
        repeat (3) @(posedge clk);
        #1;
        check("rst_st_ready", 128'(st_in_ready), 128'(0));
        check("rst_ky_ready", 128'(ky_in_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_st_valid", 128'(st_out_valid), 128'(0));
        check("rst_ky_valid", 128'(ky_out_valid), 128'(0));
        check("rst_st_data", st_out_data, 128'(0));
        check("rst_ky_data", 128'(ky_out_data), 128'(0));

        // Contention from reset: KY, ST, KY, ST, KY, ST.
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            exp_ky = (j % 2 == 0);
            #1;
            check("arb_ky_ready", 128'(ky_in_ready), 128'(exp_ky));
            check("arb_st_ready", 128'(st_in_ready), 128'(!exp_ky));
            @(posedge clk); #1;
            wait_out(exp_ky, lat, res);
            check("arb_latency", 128'(lat), exp_ky ? 128'(1) : 128'(4));
            check("arb_data", res, exp_ky ? {96'b0, KY_RES} : ST_RES);
            check("arb_no_cross", 128'(exp_ky ? st_out_valid : ky_out_valid), 128'(0));
            @(posedge clk);
        end
        st_in_valid = 1'b0;
        ky_in_valid = 1'b0;
        @(posedge clk); #1;

        // ST alone, all-zero state.
        st_in_valid = 1'b1;
        st_in_data  = '0;
        #1;
        check("st0_ready", 128'(st_in_ready), 128'(1));
        @(posedge clk); #1;
        st_in_valid = 1'b0;
        lat    = -1;
        busy_n = 0;
        res    = '0;
        for (int c = 1; c <= 10; c++) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            if (st_out_valid && lat < 0) begin
                lat = c;
                res = st_out_data;
            end
        end
        check("st0_latency", 128'(lat), 128'(4));
        check("st0_data", res, ST0_RES);
        check("st0_busy_cycles", 128'(busy_n), 128'(5));

        // ST vector and KY words.
        run_job(1'b0, ST_VEC, lat, res);
        check("st_latency", 128'(lat), 128'(4));
        check("st_data", res, ST_RES);
        run_job(1'b1, 128'(KY_VEC), lat, res);
        check("ky_latency", 128'(lat), 128'(1));
        check("ky_data", res, 128'(KY_RES));
        run_job(1'b1, 128'(KY_VEC2), lat, res);
        check("ky2_latency", 128'(lat), 128'(1));
        check("ky2_data", res, 128'(KY_RES2));

        // Backpressure in ST_DONE with a KY request waiting.
        st_out_ready = 1'b0;
        st_in_valid  = 1'b1;
        st_in_data   = ST_VEC;
        #1;
        check("bp_st_ready", 128'(st_in_ready), 128'(1));
        @(posedge clk); #1;
        st_in_valid = 1'b0;
        ky_in_valid = 1'b1;
        ky_in_data  = KY_VEC;
        #1;
        check("bp_ky_blocked_run", 128'(ky_in_ready), 128'(0));
        wait_out(1'b0, lat, res);
        check("bp_latency", 128'(lat), 128'(4));
        for (int c = 0; c < 10; c++) begin
            check("bp_hold_data", st_out_data, ST_RES);
            check("bp_hold_valid", 128'(st_out_valid), 128'(1));
            check("bp_ky_blocked", 128'(ky_in_ready), 128'(0));
            @(posedge clk); #1;
        end
        st_out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 128'(st_out_valid), 128'(0));
        check("bp_release_data", st_out_data, 128'(0));
        check("bp_ky_ready", 128'(ky_in_ready), 128'(1));
        @(posedge clk); #1;
        ky_in_valid = 1'b0;
        check("bp_ky_accepted", 128'(busy), 128'(1));
        wait_out(1'b1, lat, res);
        check("bp_ky_latency", 128'(lat), 128'(1));
        check("bp_ky_data", res, 128'(KY_RES));
        @(posedge clk); #1;

        // Reset in ST_RUN at pass counter 2.
        st_in_valid = 1'b1;
        st_in_data  = ST_VEC;
        #1;
        check("mr_st_ready", 128'(st_in_ready), 128'(1));
        @(posedge clk); #1;
        st_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b0;
        st_in_valid = 1'b1;
        ky_in_valid = 1'b1;
        ky_in_data  = KY_VEC;
        #1;
        check("mr_st_ready_low", 128'(st_in_ready), 128'(0));
        check("mr_ky_ready_low", 128'(ky_in_ready), 128'(0));
        @(posedge clk); #1;
        check("mr_busy", 128'(busy), 128'(0));
        check("mr_st_valid", 128'(st_out_valid), 128'(0));
        check("mr_st_data", st_out_data, 128'(0));
        check("mr_ky_valid", 128'(ky_out_valid), 128'(0));
        rst_n = 1'b1;
        #1;
        check("mr_arb_ky", 128'(ky_in_ready), 128'(1));
        check("mr_arb_st", 128'(st_in_ready), 128'(0));
        @(posedge clk); #1;
        st_in_valid = 1'b0;
        ky_in_valid = 1'b0;
        wait_out(1'b1, lat, res);
        check("mr_ky_data", res, 128'(KY_RES));
        check("mr_st_idle", 128'(st_out_valid), 128'(0));
        @(posedge clk); #1;

        // Other bank widths: ST then KY on all four auxiliary instances.
        for (int k = 0; k < 2; k++) begin
            aux_st_valid = (k == 0);
            aux_ky_valid = (k == 1);
            #1;
            for (int g = 0; g < 4; g++) begin
                check(k == 0 ? "aux_st_ready" : "aux_ky_ready",
                      128'(k == 0 ? aux_st_ready[g] : aux_ky_ready[g]), 128'(1));
                aux_lat[g] = -1;
                aux_res[g] = '0;
            end
            @(posedge clk); #1;
            aux_st_valid = 1'b0;
            aux_ky_valid = 1'b0;
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                for (int g = 0; g < 4; g++) begin
                    if (aux_lat[g] < 0 && (k == 0 ? aux_st_ovld[g] : aux_ky_ovld[g])) begin
                        aux_lat[g] = c;
                        aux_res[g] = (k == 0) ? aux_st_data[g] : {96'b0, aux_ky_data[g]};
                    end
                end
            end
            for (int g = 0; g < 4; g++) begin
                check(k == 0 ? "aux_st_latency" : "aux_ky_latency", 128'(aux_lat[g]),
                      128'(k == 0 ? exp_st_lat[g] : exp_ky_lat[g]));
                check(k == 0 ? "aux_st_data" : "aux_ky_data", aux_res[g],
                      (k == 0) ? ST_RES : {96'b0, KY_RES});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
